// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target and the I2C_Comm integration:
// FSM state encoding, counter widths, default address and address compare.
package i2c_target_pkg;

  localparam logic [6:0]  I2C_DEFAULT_ADDR = 7'b1010101;
  localparam int unsigned I2C_MIN_SYNC     = 2;
  localparam int unsigned BIT_CNT_W        = 3;
  localparam int unsigned BYTE_CNT_W       = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX_BYTE   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX_BYTE   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_e;

  // True when the upper seven bits of the first byte after START name this target
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] addr);
    return (addr_byte[7:1] == addr);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and flags SCL edges plus
// START/STOP conditions. START/STOP require SCL high in both the current and
// previous sample, so an SDA change coinciding with an SCL edge is a data bit.
module i2c_bus_sync
  import i2c_target_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sclRise,
  output logic sclFall,
  output logic sdaSync,
  output logic startDet,
  output logic stopDet
);

  localparam int unsigned STAGES = (SYNC_STAGES < I2C_MIN_SYNC) ? I2C_MIN_SYNC : SYNC_STAGES;

  logic [STAGES-1:0] scl_pipe;
  logic [STAGES-1:0] sda_pipe;
  logic              scl_prev;
  logic              sda_prev;
  logic              scl_now;
  logic              sda_now;

  // Synchroniser chains plus one extra sample for edge detection; idle bus is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[STAGES-2:0], scl};
      sda_pipe <= {sda_pipe[STAGES-2:0], sda};
      scl_prev <= scl_pipe[STAGES-1];
      sda_prev <= sda_pipe[STAGES-1];
    end
  end

  assign scl_now  = scl_pipe[STAGES-1];
  assign sda_now  = sda_pipe[STAGES-1];
  assign sdaSync  = sda_now;
  assign sclRise  = scl_now & ~scl_prev;
  assign sclFall  = ~scl_now & scl_prev;
  assign startDet = scl_now & scl_prev & sda_prev & ~sda_now;
  assign stopDet  = scl_now & scl_prev & ~sda_prev & sda_now;

endmodule

// File: rtl/i2c_target.sv
// I2C target answering one 7-bit address. Writes collect up to two bytes
// into a 16-bit word; reads return a latched 16-bit word high byte first.
// No clock stretching; SDA is only ever pulled low or released.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  ADDR        = I2C_DEFAULT_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SCL,
  inout  wire         SDA,
  input  logic [15:0] txData,
  output logic [15:0] rxData,
  output logic [1:0]  rxBytes,
  output logic        rxValid,
  output logic        rdReq,
  output logic        busy
);

  logic [1:0]            rst_pipe;
  logic                  rst_int_n;
  logic                  scl_rise;
  logic                  scl_fall;
  logic                  sda_s;
  logic                  start_det;
  logic                  stop_det;

  i2c_state_e            state;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [7:0]            shift_reg;
  logic [15:0]           rx_buf;
  logic [BYTE_CNT_W-1:0] rx_cnt;
  logic [15:0]           tx_word;
  logic                  tx_sel;
  logic                  ack_en;
  logic                  ack_started;
  logic                  is_write;
  logic                  sda_oe;

  // Reset is applied immediately but released in step with clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_int_n = rst_pipe[1];

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_sync (
    .clk      (clk),
    .rst_n    (rst_int_n),
    .scl      (SCL),
    .sda      (SDA),
    .sclRise  (scl_rise),
    .sclFall  (scl_fall),
    .sdaSync  (sda_s),
    .startDet (start_det),
    .stopDet  (stop_det)
  );

  assign SDA = sda_oe ? 1'b0 : 1'bz;

  // Protocol FSM: address match, ACK slots, byte shifting and payload hand-off
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift_reg   <= 8'h00;
      rx_buf      <= 16'h0000;
      rx_cnt      <= '0;
      tx_word     <= 16'h0000;
      tx_sel      <= 1'b0;
      ack_en      <= 1'b0;
      ack_started <= 1'b0;
      is_write    <= 1'b0;
      sda_oe      <= 1'b0;
      rxData      <= 16'h0000;
      rxBytes     <= 2'd0;
      rxValid     <= 1'b0;
      rdReq       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rxValid <= 1'b0;
      rdReq   <= 1'b0;
      if (start_det || stop_det) begin
        // A frame boundary delivers any complete write bytes; partial bytes are dropped
        if (is_write && (rx_cnt != 2'd0)) begin
          rxData  <= rx_buf;
          rxBytes <= rx_cnt;
          rxValid <= 1'b1;
        end
        is_write    <= 1'b0;
        rx_cnt      <= '0;
        sda_oe      <= 1'b0;
        busy        <= 1'b0;
        bit_cnt     <= '0;
        ack_started <= 1'b0;
        state       <= stop_det ? ST_IDLE : ST_ADDR;
      end else begin
        case (state)
          ST_IDLE: begin
            sda_oe <= 1'b0;
          end
          ST_ADDR: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[6:0], sda_s};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (addr_match({shift_reg[6:0], sda_s}, ADDR)) begin
                  state       <= ST_ADDR_ACK;
                  busy        <= 1'b1;
                  ack_started <= 1'b0;
                  rx_buf      <= 16'h0000;
                  rx_cnt      <= '0;
                  is_write    <= ~sda_s;
                  if (sda_s) begin
                    rdReq   <= 1'b1;
                    tx_word <= txData;
                  end
                end else begin
                  state <= ST_WAIT_STOP;
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_started) begin
                sda_oe      <= 1'b1;
                ack_started <= 1'b1;
              end else begin
                ack_started <= 1'b0;
                bit_cnt     <= '0;
                if (is_write) begin
                  sda_oe <= 1'b0;
                  state  <= ST_RX_BYTE;
                end else begin
                  // The falling edge that ends the ACK also launches the first read bit
                  sda_oe    <= ~tx_word[15];
                  shift_reg <= {tx_word[14:8], 1'b0};
                  tx_sel    <= 1'b0;
                  state     <= ST_TX_BYTE;
                end
              end
            end
          end
          ST_RX_BYTE: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[6:0], sda_s};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                case (rx_cnt)
                  2'd0: begin
                    rx_buf[15:8] <= {shift_reg[6:0], sda_s};
                    rx_cnt       <= 2'd1;
                    ack_en       <= 1'b1;
                  end
                  2'd1: begin
                    rx_buf[7:0] <= {shift_reg[6:0], sda_s};
                    rx_cnt      <= 2'd2;
                    ack_en      <= 1'b1;
                  end
                  default: begin
                    ack_en <= 1'b0;
                  end
                endcase
                ack_started <= 1'b0;
                state       <= ST_RX_ACK;
              end
            end
          end
          ST_RX_ACK: begin
            if (scl_fall) begin
              if (!ack_started) begin
                sda_oe      <= ack_en;
                ack_started <= 1'b1;
              end else begin
                sda_oe      <= 1'b0;
                ack_started <= 1'b0;
                bit_cnt     <= '0;
                state       <= ST_RX_BYTE;
              end
            end
          end
          ST_TX_BYTE: begin
            if (scl_fall) begin
              sda_oe    <= ~shift_reg[7];
              shift_reg <= {shift_reg[6:0], 1'b0};
            end else if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= ST_TX_ACK;
              end
            end
          end
          ST_TX_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
            end else if (scl_rise) begin
              if (!sda_s) begin
                // Initiator wants more: alternate high and low byte of the latched word
                tx_sel    <= ~tx_sel;
                shift_reg <= tx_sel ? tx_word[15:8] : tx_word[7:0];
                bit_cnt   <= '0;
                state     <= ST_TX_BYTE;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end
          end
          ST_WAIT_STOP: begin
            sda_oe <= 1'b0;
          end
          default: begin
            sda_oe <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
